// File: rtl/mgt01_div_issue_ctrl_pkg.sv
// Shared types and constants for the divide issue controller and its special-case detector.
package mgt01_div_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      DIV_  = 2'd0,
      DIVU_ = 2'd1,
      REM_  = 2'd2,
      REMU_ = 2'd3
   } div_ops_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      SPECIAL = 2'd2,
      DONE    = 2'd3
   } div_ctrl_state_e;

   localparam int XLEN_C        = 32;
   localparam int TAG_W_C       = 5;
   localparam int DIV_LATENCY_C = 34;

   localparam logic [XLEN_C-1:0] DIV_ZERO_Q_C = '1;
   localparam logic [XLEN_C-1:0] INT_MIN_C    = 32'h8000_0000;

endpackage

// File: rtl/mgt01_div_special_detect.sv
// Flags requests whose RISC-V result is fixed by the ISA (divide-by-zero, signed overflow)
// and produces that result directly, so the divide unit never has to run for them.
module mgt01_div_special_detect
   import mgt01_div_issue_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_C
) (
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  div_ops_e        op,
   output logic            is_special,
   output logic [XLEN-1:0] special_result
);

   localparam logic [XLEN-1:0] ALL_ONES = '1;
   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   logic is_rem;
   logic div_by_zero;
   logic overflow;

   always_comb begin
      is_rem         = (op == REM_) || (op == REMU_);
      div_by_zero    = (divisor == '0);
      overflow       = ((op == DIV_) || (op == REM_)) &&
                       (dividend == INT_MIN) && (divisor == ALL_ONES);
      is_special     = div_by_zero || overflow;
      special_result = '0;
      if (div_by_zero) begin
         special_result = is_rem ? dividend : ALL_ONES;
      end else if (overflow) begin
         special_result = is_rem ? '0 : INT_MIN;
      end
   end

endmodule

// File: rtl/mgt01_div_issue_ctrl.sv
// Single-entry issue controller in front of the fixed-latency divide unit: latches one
// request, resolves special cases locally, times the divider and holds the writeback.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | ready for a request; divide unit held in reset
//   RUN     | divide unit clocked; counting its fixed latency
//   SPECIAL | result already known from the operands; one-cycle slot
//   DONE    | result and tag presented until the writeback handshake
module mgt01_div_issue_ctrl
   import mgt01_div_issue_ctrl_pkg::*;
#(
   parameter int XLEN        = XLEN_C,
   parameter int DIV_LATENCY = DIV_LATENCY_C,
   parameter int TAG_W       = TAG_W_C
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [XLEN-1:0]  req_dividend_i,
   input  logic [XLEN-1:0]  req_divisor_i,
   input  div_ops_e         req_op_i,
   input  logic [TAG_W-1:0] req_rd_i,
   output logic [XLEN-1:0]  div_dividend_o,
   output logic [XLEN-1:0]  div_divisor_o,
   output div_ops_e         div_op_o,
   output logic             div_clk_en_o,
   output logic             div_rst_n_o,
   input  logic [XLEN-1:0]  div_result_i,
   output logic             wb_valid_o,
   input  logic             wb_ready_i,
   output logic [XLEN-1:0]  wb_result_o,
   output logic [TAG_W-1:0] wb_rd_o,
   output logic             busy_o
);

   localparam int               CNT_W    = $clog2(DIV_LATENCY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

   div_ctrl_state_e  state;
   div_ctrl_state_e  state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  dividend_q;
   logic [XLEN-1:0]  divisor_q;
   logic [XLEN-1:0]  result_q;
   div_ops_e         op_q;
   logic [TAG_W-1:0] rd_q;
   logic             accept;
   logic             cnt_done;
   logic             is_special;
   logic [XLEN-1:0]  special_result;

   mgt01_div_special_detect #(.XLEN(XLEN)) u_special_detect (
      .dividend       (req_dividend_i),
      .divisor        (req_divisor_i),
      .op             (req_op_i),
      .is_special     (is_special),
      .special_result (special_result)
   );

   assign cnt_done = (cnt == CNT_LAST);

   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      req_ready_o  = 1'b0;
      busy_o       = 1'b1;
      div_clk_en_o = 1'b0;
      div_rst_n_o  = 1'b1;
      wb_valid_o   = 1'b0;
      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
            div_rst_n_o = 1'b0;
            if (req_valid_i && !flush_i) begin
               accept    = 1'b1;
               state_nxt = is_special ? SPECIAL : RUN;
            end
         end
         RUN: begin
            div_clk_en_o = 1'b1;
            if (cnt_done) state_nxt = DONE;
         end
         SPECIAL: state_nxt = DONE;
         DONE: begin
            wb_valid_o = 1'b1;
            if (wb_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Flush wins over every transition and holds the divider in reset so its work is dropped.
      if (flush_i) begin
         state_nxt   = IDLE;
         div_rst_n_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         result_q   <= '0;
         op_q       <= DIV_;
         rd_q       <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            dividend_q <= req_dividend_i;
            divisor_q  <= req_divisor_i;
            op_q       <= req_op_i;
            rd_q       <= req_rd_i;
            cnt        <= '0;
            if (is_special) result_q <= special_result;
         end else if (state == RUN && !flush_i) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt_done) result_q <= div_result_i;
         end
      end
   end

   assign div_dividend_o = dividend_q;
   assign div_divisor_o  = divisor_q;
   assign div_op_o       = op_q;
   assign wb_result_o    = result_q;
   assign wb_rd_o        = rd_q;

endmodule

// File: tb/tb_mgt01_div_issue_ctrl.sv
// Scoreboard bench for the divide issue controller with a behavioural fixed-latency divider.
module tb_mgt01_div_issue_ctrl;
   import mgt01_div_issue_ctrl_pkg::*;

   localparam int LAT = 34;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_dividend_i = '0;
   logic [31:0] req_divisor_i = '0;
   div_ops_e    req_op_i = DIV_;
   logic [4:0]  req_rd_i = '0;
   logic [31:0] div_dividend_o;
   logic [31:0] div_divisor_o;
   div_ops_e    div_op_o;
   logic        div_clk_en_o;
   logic        div_rst_n_o;
   logic [31:0] div_result_i;
   logic        wb_valid_o;
   logic        wb_ready_i = 1'b0;
   logic [31:0] wb_result_o;
   logic [4:0]  wb_rd_o;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   mgt01_div_issue_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_dividend_i (req_dividend_i),
      .req_divisor_i  (req_divisor_i),
      .req_op_i       (req_op_i),
      .req_rd_i       (req_rd_i),
      .div_dividend_o (div_dividend_o),
      .div_divisor_o  (div_divisor_o),
      .div_op_o       (div_op_o),
      .div_clk_en_o   (div_clk_en_o),
      .div_rst_n_o    (div_rst_n_o),
      .div_result_i   (div_result_i),
      .wb_valid_o     (wb_valid_o),
      .wb_ready_i     (wb_ready_i),
      .wb_result_o    (wb_result_o),
      .wb_rd_o        (wb_rd_o),
      .busy_o         (busy_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      div_ops_e    op;
      logic [4:0]  rd;
      int          lat;
      int          acc;
      bit          special;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bit is_special_f(div_ops_e op, logic [31:0] a, logic [31:0] b);
      return (b == 32'd0) ||
             ((op == DIV_ || op == REM_) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // RISC-V M-extension divide/remainder semantics from plain arithmetic.
   function automatic logic [31:0] ref_div(div_ops_e op, logic [31:0] a, logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return (op == DIV_ || op == DIVU_) ? 32'hFFFF_FFFF : a;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         if (op == DIV_) return 32'h8000_0000;
         if (op == REM_) return 32'd0;
      end
      case (op)
         DIV_:    return sa / sb;
         DIVU_:   return a / b;
         REM_:    return sa % sb;
         default: return a % b;
      endcase
   endfunction

   // Divider model: result is only correct once it has been clocked LAT-1 times out of reset.
   int          en_cnt = 0;
   logic [31:0] model_q;
   always @(posedge clk_i) begin
      if (!div_rst_n_o) en_cnt <= 0;
      else if (div_clk_en_o) en_cnt <= en_cnt + 1;
   end
   always_comb begin
      model_q      = ref_div(div_op_o, div_dividend_o, div_divisor_o);
      div_result_i = (en_cnt >= LAT - 1) ? model_q : ~model_q;
   end

   // Monitor/scoreboard, sampling mid-cycle.
   initial begin
      int   d;
      bit   empty;
      bit   run_exp;
      bit   valid_exp;
      exp_t e;
      exp_t n;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (rst_i || flush_i) begin
            exp_q.delete();
         end else begin
            empty     = (exp_q.size() == 0);
            run_exp   = 1'b0;
            valid_exp = 1'b0;
            if (!empty) begin
               e         = exp_q[0];
               d         = cyc - e.acc;
               run_exp   = !e.special && d >= 1 && d <= LAT;
               valid_exp = d >= e.lat;
            end
            chk("req_ready", req_ready_o, empty);
            chk("busy", busy_o, !empty);
            chk("wb_valid", wb_valid_o, valid_exp);
            chk("div_clk_en", div_clk_en_o, run_exp);
            chk("div_rst_n", div_rst_n_o, !empty);
            if (run_exp) begin
               chk("div_dividend", div_dividend_o, e.a);
               chk("div_divisor", div_divisor_o, e.b);
               chk("div_op", div_op_o, e.op);
            end
            if (valid_exp && wb_valid_o) begin
               chk("wb_result", wb_result_o, e.res);
               chk("wb_rd", wb_rd_o, e.rd);
               if (wb_ready_i) void'(exp_q.pop_front());
            end
            if (empty && req_valid_i && req_ready_o) begin
               n.a       = req_dividend_i;
               n.b       = req_divisor_i;
               n.op      = req_op_i;
               n.rd      = req_rd_i;
               n.special = is_special_f(req_op_i, req_dividend_i, req_divisor_i);
               n.res     = ref_div(req_op_i, req_dividend_i, req_divisor_i);
               n.lat     = n.special ? 2 : LAT + 1;
               n.acc     = cyc;
               exp_q.push_back(n);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_req(input div_ops_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
      req_valid_i    = 1'b1;
      req_op_i       = op;
      req_dividend_i = a;
      req_divisor_i  = b;
      req_rd_i       = rd;
      step();
      req_valid_i    = 1'b0;
      req_dividend_i = $urandom;
      req_divisor_i  = $urandom;
      req_rd_i       = 5'($urandom);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!wb_valid_o && n < 200) begin
         step();
         n++;
      end
      if (!wb_valid_o) chk("wb_valid_timeout", wb_valid_o, 1);
   endtask

   task automatic issue(input div_ops_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold, input bit rdy_early);
      wb_ready_i = rdy_early;
      drive_req(op, a, b, rd);
      wait_valid();
      repeat (hold) step();
      wb_ready_i = 1'b1;
      step();
      wb_ready_i = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req_ready"}, req_ready_o, 1);
      chk({tag, "_wb_valid"}, wb_valid_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_div_clk_en"}, div_clk_en_o, 0);
      chk({tag, "_div_rst_n"}, div_rst_n_o, 0);
      chk({tag, "_wb_result"}, wb_result_o, 0);
      chk({tag, "_wb_rd"}, wb_rd_o, 0);
      chk({tag, "_div_dividend"}, div_dividend_o, 0);
      chk({tag, "_div_divisor"}, div_divisor_o, 0);
      chk({tag, "_div_op"}, div_op_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      div_ops_e    op;
      repeat (3) step();
      rst_i = 1'b0;
      check_reset_vals("reset");

      issue(DIV_, 32'd100, 32'hFFFF_FFF9, 5'd3, 0, 1'b0);
      issue(REMU_, 32'h1234, 32'd0, 5'd4, 0, 1'b0);
      issue(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, 1'b0);
      issue(REM_, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1, 1'b0);
      issue(DIVU_, 32'hFFFF_FFFF, 32'd2, 5'd7, 10, 1'b0);
      issue(DIV_, 32'd9, 32'd0, 5'd8, 0, 1'b1);

      // Flush in the middle of a running divide.
      drive_req(DIV_, 32'd1000, 32'd3, 5'd9);
      repeat (14) step();
      flush_i = 1'b1;
      #1;
      chk("div_rst_n_on_flush", div_rst_n_o, 0);
      step();
      flush_i = 1'b0;
      chk("state_after_flush", busy_o, 0);
      repeat (5) step();
      issue(DIV_, 32'd7, 32'd2, 5'd10, 0, 1'b0);

      // Flush together with a request in IDLE: must not be accepted.
      flush_i        = 1'b1;
      req_valid_i    = 1'b1;
      req_op_i       = DIVU_;
      req_dividend_i = 32'd50;
      req_divisor_i  = 32'd5;
      step();
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      chk("flush_blocks_accept", busy_o, 0);
      step();

      for (int i = 0; i < 40; i++) begin
         op = div_ops_e'($urandom_range(0, 3));
         a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         issue(op, a, b, 5'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Synchronous reset while a result is waiting in DONE.
      drive_req(REM_, 32'hFFFF_FF9C, 32'd7, 5'd21);
      wait_valid();
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check_reset_vals("reset_in_done");
      repeat (3) step();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
